heartbeat_ctrl: RTL and testbench
=================================

HEARTBEAT_CTRL -- requirements
Module: heartbeat_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8: width of the period, width and count registers.
REQ-002 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port cfg_we, input, 1: configuration write strobe; one write per asserted cycle.
REQ-005 Port cfg_addr, input, 2: register select (0 PERIOD, 1 WIDTH, 2 COUNT, 3 reserved).
REQ-006 Port cfg_wdata, input, N: write data.
REQ-007 Port start, input, 1: begin pulse sequence.
REQ-008 Port stop, input, 1: abort pulse sequence.
REQ-009 Port out, output, 1: registered heartbeat pulse.
REQ-010 Port busy, output, 1: high whenever the state is not IDLE.
REQ-011 Port done, output, 1: one-cycle pulse on normal completion of a finite sequence.

Function
REQ-012 The block SHALL hold three programmed registers, PERIOD, WIDTH and COUNT, each written on cfg_we at cfg_addr; a write to address 3 SHALL have no effect.
REQ-013 On an accepted start, the block SHALL copy the programmed registers into shadow registers; writes while busy SHALL update only the programmed registers, effective at the next start.
REQ-014 Effective width We SHALL be max(WIDTH,1); effective period Pe SHALL be PERIOD if PERIOD>We, else We+1, computed in N+1 bits with no wrap.
REQ-015 The FSM SHALL have states IDLE, HIGH and LOW; out SHALL be 1 exactly when the state is HIGH.
REQ-016 start in IDLE at cycle t (stop low) SHALL give out=1 on cycles t+1..t+We, then out=0 for Pe-We cycles, repeating.
REQ-017 HIGH->LOW SHALL occur after We cycles in HIGH; LOW->HIGH SHALL occur after Pe-We cycles in LOW, unless the pulse count is exhausted.
REQ-018 A shadow COUNT of 0 SHALL mean run indefinitely; otherwise the block SHALL emit exactly COUNT pulses and return to IDLE at the end of the last LOW phase.
REQ-019 done SHALL be 1 on the first IDLE cycle after a finite sequence, and 0 otherwise.
REQ-020 start while busy SHALL be ignored.
REQ-021 stop SHALL take priority over start; stop in HIGH or LOW SHALL force IDLE and out=0 on the next cycle, with no done.
REQ-022 stop while IDLE SHALL have no effect; start and stop together in IDLE SHALL leave the block in IDLE.
REQ-023 The phase counter SHALL be N+1 bits, clear on every phase entry, and never wrap within a phase.
REQ-024 The pulse counter SHALL be N bits and SHALL not decrement when shadow COUNT is 0.

Reset
REQ-025 reset SHALL override all other inputs on the same edge.
REQ-026 After reset: state IDLE, out=0, busy=0, done=0, all programmed, shadow and internal counters 0.
REQ-027 Reset asserted mid-sequence SHALL take effect on the next edge with no done pulse.

Structure
REQ-028 A shared package heartbeat_pkg SHALL hold the state encoding (IDLE, HIGH, LOW) and the register address constants (ADDR_PERIOD=0, ADDR_WIDTH=1, ADDR_COUNT=2).
REQ-029 The register file and shadow copy SHALL be a sub-module heartbeat_regs; the FSM and counters SHALL stay in heartbeat_ctrl.

Verification
REQ-030 PERIOD=5, WIDTH=2, COUNT=3, start at cycle 10 -> out high on 11-12, 16-17, 21-22; done on 26; busy on 11-25.
REQ-031 WIDTH=0, PERIOD=0, COUNT=2 -> We=1, Pe=2; out pattern 1,0,1,0, then done.
REQ-032 COUNT=0, PERIOD=4, WIDTH=1, run 100 cycles, then stop during HIGH -> out=0 and busy=0 on the next cycle; done never asserts.
REQ-033 Write PERIOD=9 while busy with PERIOD=5 -> current sequence keeps period 5; the next start uses period 9.
REQ-034 start and stop together in IDLE -> remains IDLE; start pulsed while busy -> no change to timing.
REQ-035 reset asserted mid-LOW -> next cycle out=0, busy=0, done=0, registers read back 0 (PERIOD=0 gives Pe=2 on the next start).

Source files
------------

// File: rtl/heartbeat_pkg.sv
// rtl/heartbeat_pkg.sv - shared state encoding and register addresses for heartbeat_ctrl
package heartbeat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_WIDTH  = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

endpackage

// File: rtl/heartbeat_regs.sv
// rtl/heartbeat_regs.sv - programmed PERIOD/WIDTH/COUNT registers and their shadow copy
// Ports: clk/reset (sync, active high); cfg_we/cfg_addr/cfg_wdata write the
// programmed registers; load copies programmed -> shadow; prog_count is the
// live programmed COUNT; sh_* are the shadow values used by the running sequence.
module heartbeat_regs
  import heartbeat_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_addr,
  input  logic [N-1:0] cfg_wdata,
  input  logic         load,
  output logic [N-1:0] prog_count,
  output logic [N-1:0] sh_period,
  output logic [N-1:0] sh_width,
  output logic [N-1:0] sh_count
);

  logic [N-1:0] prog_period;
  logic [N-1:0] prog_width;

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_period <= '0;
      prog_width  <= '0;
      prog_count  <= '0;
    end else if (cfg_we) begin
      // Address 3 is reserved and falls through with no effect.
      case (cfg_addr)
        ADDR_PERIOD: prog_period <= cfg_wdata;
        ADDR_WIDTH:  prog_width  <= cfg_wdata;
        ADDR_COUNT:  prog_count  <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // A write coinciding with load lands in the programmed register only;
  // the shadow takes the value held before that write.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_period <= '0;
      sh_width  <= '0;
      sh_count  <= '0;
    end else if (load) begin
      sh_period <= prog_period;
      sh_width  <= prog_width;
      sh_count  <= prog_count;
    end
  end

endmodule

// File: rtl/heartbeat_ctrl.sv
// rtl/heartbeat_ctrl.sv - periodic heartbeat pulse generator with finite/infinite pulse count
// Ports: clk, reset (sync, active high); cfg_we/cfg_addr/cfg_wdata program
// PERIOD(0)/WIDTH(1)/COUNT(2); start/stop control a sequence; out is the
// pulse, busy is high outside IDLE, done pulses once after a finite sequence.
module heartbeat_ctrl
  import heartbeat_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_addr,
  input  logic [N-1:0] cfg_wdata,
  input  logic         start,
  input  logic         stop,
  output logic         out,
  output logic         busy,
  output logic         done
);

  state_t       state, state_nx;
  logic         load;
  logic         done_nx;
  logic [N:0]   phase_cnt;
  logic [N-1:0] pulse_cnt;

  logic [N-1:0] prog_count;
  logic [N-1:0] sh_period;
  logic [N-1:0] sh_width;
  logic [N-1:0] sh_count;

  logic [N:0]   we_eff;
  logic [N:0]   pe_eff;
  logic [N:0]   low_len;
  logic         finite;
  logic         high_end;
  logic         low_end;
  logic         last_pulse;

  heartbeat_regs #(.N(N)) u_regs (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .load       (load),
    .prog_count (prog_count),
    .sh_period  (sh_period),
    .sh_width   (sh_width),
    .sh_count   (sh_count)
  );

  // Effective timing in N+1 bits so We+1 cannot wrap when WIDTH is all ones.
  always_comb begin
    we_eff     = (sh_width == '0) ? (N+1)'(1) : {1'b0, sh_width};
    pe_eff     = ({1'b0, sh_period} > we_eff) ? {1'b0, sh_period} : we_eff + (N+1)'(1);
    low_len    = pe_eff - we_eff;
    finite     = (sh_count != '0);
    high_end   = (phase_cnt == we_eff - (N+1)'(1));
    low_end    = (phase_cnt == low_len - (N+1)'(1));
    last_pulse = finite && (pulse_cnt == N'(1));
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx = HIGH;
          load     = 1'b1;
        end
      end
      HIGH: begin
        if (stop)          state_nx = IDLE;
        else if (high_end) state_nx = LOW;
      end
      LOW: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (low_end) begin
          if (last_pulse) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = HIGH;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      phase_cnt <= '0;
      pulse_cnt <= '0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      // Cleared on every phase entry; phases are at most 2^N cycles so
      // the N+1 bit counter never wraps while a phase is running.
      if (state_nx != state || state_nx == IDLE)
        phase_cnt <= '0;
      else
        phase_cnt <= phase_cnt + (N+1)'(1);
      // Pulse count comes straight from the programmed COUNT at start,
      // matching the value being copied into the shadow on the same edge.
      if (load)
        pulse_cnt <= prog_count;
      else if (state == LOW && !stop && low_end && finite)
        pulse_cnt <= pulse_cnt - N'(1);
    end
  end

  assign out  = (state == HIGH);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_heartbeat_ctrl.sv
// tb/tb_heartbeat_ctrl.sv - directed self-checking bench for heartbeat_ctrl
module tb_heartbeat_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       start;
  logic       stop;
  logic       out;
  logic       busy;
  logic       done;

  int total  = 0;
  int passed = 0;

  heartbeat_ctrl #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .stop      (stop),
    .out       (out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp is {out, busy, done}
  task automatic chk(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {out, busy, done};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: out/busy/done observed %b expected %b", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Checks a pulse train starting on the first HIGH cycle: npulse pulses of
  // hi cycles high and lo cycles low, then (if fin) a done cycle and quiet IDLE.
  task automatic train(input string tag, input int hi, input int lo,
                       input int npulse, input bit fin);
    for (int p = 0; p < npulse; p++) begin
      for (int i = 0; i < hi; i++) begin chk({tag, "_high"}, 3'b110); tick(); end
      for (int i = 0; i < lo; i++) begin chk({tag, "_low"}, 3'b010); tick(); end
    end
    if (fin) begin
      chk({tag, "_done"}, 3'b001);
      tick();
      chk({tag, "_idle"}, 3'b000);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b1; stop = 1'b0;
    tick();
    tick();
    chk("reset_state", 3'b000);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("post_reset_idle", 3'b000);

    // PERIOD=5 WIDTH=2 COUNT=3: 2 high, 3 low, x3, then done.
    wr(2'd0, 8'd5); wr(2'd1, 8'd2); wr(2'd2, 8'd3);
    do_start();
    train("p5w2c3", 2, 3, 3, 1'b1);

    // WIDTH=0 PERIOD=0 COUNT=2: We=1, Pe=2.
    wr(2'd0, 8'd0); wr(2'd1, 8'd0); wr(2'd2, 8'd2);
    do_start();
    train("p0w0c2", 1, 1, 2, 1'b1);

    // COUNT=0 PERIOD=4 WIDTH=1: infinite; 100 cycles then stop in HIGH.
    wr(2'd0, 8'd4); wr(2'd1, 8'd1); wr(2'd2, 8'd0);
    do_start();
    train("inf", 1, 3, 25, 1'b0);
    chk("inf_high_before_stop", 3'b110);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_in_high", 3'b000);
    tick();
    chk("stop_no_done", 3'b000);

    // PERIOD=5 WIDTH=2 COUNT=2, rewrite PERIOD=9 while busy.
    wr(2'd0, 8'd5); wr(2'd1, 8'd2); wr(2'd2, 8'd2);
    do_start();
    chk("busy_wr_h0", 3'b110);
    wr(2'd0, 8'd9);
    chk("busy_wr_h1", 3'b110);
    tick();
    train("old_period", 0, 3, 1, 1'b0);
    train("old_period2", 2, 3, 1, 1'b1);
    tick();
    do_start();
    train("new_period", 2, 7, 2, 1'b1);

    // Reserved address write has no effect on timing.
    wr(2'd3, 8'hFF);
    // start+stop together in IDLE stays IDLE.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 3'b000);
    tick();
    chk("start_stop_idle2", 3'b000);

    // start pulsed while busy leaves timing unchanged.
    do_start();
    chk("ign_h0", 3'b110);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_h1", 3'b110);
    tick();
    train("ign_rest", 0, 7, 1, 1'b0);
    train("ign_rest2", 2, 7, 1, 1'b1);

    // Reset mid-LOW, then registers are zero: We=1, Pe=2, infinite.
    wr(2'd0, 8'd5); wr(2'd1, 8'd2); wr(2'd2, 8'd0);
    do_start();
    chk("rst_h0", 3'b110); tick();
    chk("rst_h1", 3'b110); tick();
    chk("rst_l0", 3'b010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_low", 3'b000);
    do_start();
    train("after_reset", 1, 1, 2, 1'b0);
    chk("after_reset_h", 3'b110); tick();
    chk("after_reset_l", 3'b010);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_in_low", 3'b000);
    tick();
    chk("stop_low_no_done", 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
